// File: rtl/clk_rst_pkg.sv
// ---------------------------------------------------------------------------
// clk_rst_pkg
// Shared types and constants for the clock-enable / reset sequencer.
//   seq_state_t      : sequencer FSM states
//   LOSS_CNT_W       : width of the lock-loss event counter
//   DEF_LOCK_STABLE  : default lock-stable qualification length (cycles)
//   DEF_RST_STAGGER  : default spacing between channel reset releases (cycles)
// ---------------------------------------------------------------------------
package clk_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam int LOSS_CNT_W      = 8;
    localparam int DEF_LOCK_STABLE = 1024;
    localparam int DEF_RST_STAGGER = 16;

endpackage

// File: rtl/clk_rst_seq_ce_div.sv
// ---------------------------------------------------------------------------
// ce_div
// Single-channel clock-enable divider. Produces a one-cycle strobe every
// i_ratio cycles (every cycle for ratios 0 and 1) while out of reset.
// Ports:
//   i_clk   : system clock
//   i_rst   : synchronous reset, active-high; holds the count at 0
//   i_ratio : divide ratio, may change at any time
//   o_ce    : registered clock-enable strobe
// ---------------------------------------------------------------------------
module ce_div #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [DIV_W-1:0] i_ratio,
    output logic             o_ce
);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_ce;
    logic             w_wrap;

    // The >= compare makes a reduced ratio wrap at once instead of running
    // the counter up to its maximum; it also keeps the increment from
    // ever overflowing.
    assign w_wrap = (i_ratio <= DIV_W'(1)) || (r_div_cnt >= (i_ratio - DIV_W'(1)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div_cnt <= '0;
            r_ce      <= 1'b0;
        end else if (w_wrap) begin
            r_div_cnt <= '0;
            r_ce      <= 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
            r_ce      <= 1'b0;
        end
    end

    assign o_ce = r_ce;

endmodule

// File: rtl/clk_rst_seq.sv
// ---------------------------------------------------------------------------
// clk_rst_seq
// Synchronises and qualifies the MMCM LOCKED flag, releases per-channel
// synchronous resets in a staggered order, and generates per-channel divided
// clock-enable strobes. Any loss of lock re-asserts every channel reset.
//
// Optional feature macro: LOCK_LOSS_CNT_EN adds lock_lost_cnt_o, a saturating
// count of lock-loss events cleared only by sys_rst.
//
// Ports:
//   sys_clk         : system clock, rising edge
//   sys_rst         : synchronous reset, active-high
//   pll_locked_i    : MMCM LOCKED, asynchronous to sys_clk
//   div_ratio_i     : per-channel divide ratio, channel k at [k*DIV_W +: DIV_W]
//   ce_o            : per-channel one-cycle clock-enable strobe
//   ch_rst_o        : per-channel synchronous reset, active-high
//   all_ready_o     : every channel released and lock good
//   lock_lost_cnt_o : lock-loss event count (LOCK_LOSS_CNT_EN only)
//
// state     | meaning
// ----------+------------------------------------------------------------
// WAIT_LOCK | all channels in reset, waiting for synchronised lock
// STABLE    | lock seen, counting consecutive good cycles
// RELEASE   | releasing channel resets one by one, RST_STAGGER apart
// RUN       | all channels released, all_ready_o high
// ---------------------------------------------------------------------------
module clk_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 16,
    parameter int LOCK_STABLE = DEF_LOCK_STABLE,
    parameter int RST_STAGGER = DEF_RST_STAGGER
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    pll_locked_i,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio_i,
    output logic [NUM_CH-1:0]       ce_o,
    output logic [NUM_CH-1:0]       ch_rst_o,
    output logic                    all_ready_o
`ifdef LOCK_LOSS_CNT_EN
    ,
    output logic [LOSS_CNT_W-1:0]   lock_lost_cnt_o
`endif
);

    localparam int STAB_W = $clog2(LOCK_STABLE);
    localparam int GAP_W  = $clog2(RST_STAGGER + 1);
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RST_STAGGER - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CH - 1);

    logic              r_sync1;
    logic              r_lock_s;
    seq_state_t        r_state;
    logic [STAB_W-1:0] r_stab_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [IDX_W-1:0]  r_rel_idx;
    logic [NUM_CH-1:0] r_ch_rst;
    logic              r_all_ready;

    seq_state_t        w_state_nxt;
    logic [STAB_W-1:0] w_stab_nxt;
    logic [GAP_W-1:0]  w_gap_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [NUM_CH-1:0] w_ch_rst_nxt;
    logic              w_ready_nxt;
    logic [NUM_CH-1:0] w_div_rst;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sync1     <= 1'b0;
            r_lock_s    <= 1'b0;
            r_state     <= WAIT_LOCK;
            r_stab_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_rel_idx   <= '0;
            r_ch_rst    <= '1;
            r_all_ready <= 1'b0;
        end else begin
            r_sync1     <= pll_locked_i;
            r_lock_s    <= r_sync1;
            r_state     <= w_state_nxt;
            r_stab_cnt  <= w_stab_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_rel_idx   <= w_idx_nxt;
            r_ch_rst    <= w_ch_rst_nxt;
            r_all_ready <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_stab_nxt   = r_stab_cnt;
        w_gap_nxt    = r_gap_cnt;
        w_idx_nxt    = r_rel_idx;
        w_ch_rst_nxt = r_ch_rst;
        w_ready_nxt  = r_all_ready;

        case (r_state)
            WAIT_LOCK: begin
                w_stab_nxt   = '0;
                w_gap_nxt    = '0;
                w_idx_nxt    = '0;
                w_ch_rst_nxt = '1;
                w_ready_nxt  = 1'b0;
                if (r_lock_s) begin
                    w_state_nxt = STABLE;
                end
            end
            STABLE: begin
                if (r_stab_cnt == STAB_LAST) begin
                    w_state_nxt     = RELEASE;
                    w_stab_nxt      = '0;
                    w_gap_nxt       = '0;
                    w_idx_nxt       = '0;
                    w_ch_rst_nxt[0] = 1'b0;
                end else begin
                    w_stab_nxt = r_stab_cnt + STAB_W'(1);
                end
            end
            RELEASE: begin
                // The last channel was released on entry to this cycle, so
                // all_ready_o follows one cycle behind its reset falling.
                if (r_rel_idx == IDX_LAST) begin
                    w_state_nxt = RUN;
                    w_gap_nxt   = '0;
                    w_ready_nxt = 1'b1;
                end else if (r_gap_cnt == GAP_LAST) begin
                    w_gap_nxt = '0;
                    w_idx_nxt = r_rel_idx + IDX_W'(1);
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (k == int'(r_rel_idx) + 1) begin
                            w_ch_rst_nxt[k] = 1'b0;
                        end
                    end
                end else begin
                    w_gap_nxt = r_gap_cnt + GAP_W'(1);
                end
            end
            RUN: begin
                w_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt  = WAIT_LOCK;
                w_ch_rst_nxt = '1;
                w_ready_nxt  = 1'b0;
            end
        endcase

        // Loss of lock overrides every other transition.
        if ((r_state != WAIT_LOCK) && !r_lock_s) begin
            w_state_nxt  = WAIT_LOCK;
            w_stab_nxt   = '0;
            w_gap_nxt    = '0;
            w_idx_nxt    = '0;
            w_ch_rst_nxt = '1;
            w_ready_nxt  = 1'b0;
        end
    end

    assign ch_rst_o    = r_ch_rst;
    assign all_ready_o = r_all_ready;

    // Dividers reset on the same edge ch_rst_o rises (lock loss or sys_rst)
    // but only start counting once ch_rst_o is actually low.
    assign w_div_rst = r_ch_rst | w_ch_rst_nxt | {NUM_CH{sys_rst}};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        ce_div #(
            .DIV_W (DIV_W)
        ) u_ce_div (
            .i_clk   (sys_clk),
            .i_rst   (w_div_rst[k]),
            .i_ratio (div_ratio_i[k*DIV_W +: DIV_W]),
            .o_ce    (ce_o[k])
        );
    end

`ifdef LOCK_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] r_lost_cnt;
    logic                  w_loss;

    assign w_loss = (r_state != WAIT_LOCK) && !r_lock_s;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_lost_cnt <= '0;
        end else if (w_loss && (r_lost_cnt != '1)) begin
            r_lost_cnt <= r_lost_cnt + LOSS_CNT_W'(1);
        end
    end

    assign lock_lost_cnt_o = r_lost_cnt;
`endif

endmodule

// File: tb/tb_clk_rst_seq.sv
module tb_clk_rst_seq;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 16;
    localparam int LS     = 8;
    localparam int RS     = 4;

    logic                    sys_clk = 1'b0;
    logic                    sys_rst;
    logic                    pll_locked_i;
    logic [NUM_CH*DIV_W-1:0] div_ratio_i;
    logic [NUM_CH-1:0]       ce_o;
    logic [NUM_CH-1:0]       ch_rst_o;
    logic                    all_ready_o;
`ifdef LOCK_LOSS_CNT_EN
    logic [7:0]              lock_lost_cnt_o;
`endif

    always #5 sys_clk = ~sys_clk;

    clk_rst_seq #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .LOCK_STABLE (LS),
        .RST_STAGGER (RS)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .pll_locked_i    (pll_locked_i),
        .div_ratio_i     (div_ratio_i),
        .ce_o            (ce_o),
        .ch_rst_o        (ch_rst_o),
        .all_ready_o     (all_ready_o)
`ifdef LOCK_LOSS_CNT_EN
        ,
        .lock_lost_cnt_o (lock_lost_cnt_o)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: lock_s is the input delayed two cycles; everything
    // else follows from how long lock_s has been continuously good.
    bit              m_sync1  = 1'b0;
    bit              m_lock_s = 1'b0;
    int              m_run    = 0;
    bit [NUM_CH-1:0] m_rel    = '0;
    bit              m_ready  = 1'b0;
    bit [NUM_CH-1:0] m_ce     = '0;
    int              m_anchor [NUM_CH];
    int              m_lost   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int ratio_of(input int k);
        return int'(div_ratio_i[k*DIV_W +: DIV_W]);
    endfunction

    task automatic set_ratio(input int k, input int v);
        div_ratio_i[k*DIV_W +: DIV_W] = DIV_W'(v);
    endtask

    task automatic tick();
        bit [NUM_CH-1:0] prev_rel;
        bit [NUM_CH-1:0] exp_rst;
        int r;
        @(posedge sys_clk);
        cyc++;
        prev_rel = m_rel;
        if (sys_rst) begin
            m_sync1  = 1'b0;
            m_lock_s = 1'b0;
            m_run    = 0;
            m_rel    = '0;
            m_ready  = 1'b0;
            m_ce     = '0;
            m_lost   = 0;
        end else begin
            if (m_lock_s) begin
                if (m_run < 1000000) m_run++;
            end else begin
                if (m_run > 0 && m_lost < 255) m_lost++;
                m_run = 0;
            end
            for (int k = 0; k < NUM_CH; k++)
                m_rel[k] = (m_run >= LS + 1 + k * RS);
            m_ready = (m_run >= LS + 2 + (NUM_CH - 1) * RS);
            for (int k = 0; k < NUM_CH; k++) begin
                m_ce[k] = 1'b0;
                if (m_rel[k] && !prev_rel[k]) begin
                    m_anchor[k] = cyc;
                end else if (m_rel[k] && prev_rel[k]) begin
                    r = ratio_of(k);
                    if (r < 1) r = 1;
                    if (cyc - m_anchor[k] >= r) begin
                        m_ce[k]     = 1'b1;
                        m_anchor[k] = cyc;
                    end
                end
            end
            m_lock_s = m_sync1;
            m_sync1  = pll_locked_i;
        end
        @(negedge sys_clk);
        exp_rst = ~m_rel;
        chk_eq("ch_rst", ch_rst_o, exp_rst);
        chk_eq("ce", ce_o, m_ce);
        chk_eq("ready", all_ready_o, m_ready);
`ifdef LOCK_LOSS_CNT_EN
        chk_eq("lost_cnt", lock_lost_cnt_o, m_lost);
`endif
    endtask

    // sel < NUM_CH: wait for ch_rst_o[sel] low; sel == NUM_CH: all_ready_o high.
    task automatic wait_evt(input int sel, input int budget, output int t);
        bit hit;
        t = -1;
        for (int i = 0; i <= budget; i++) begin
            hit = (sel < NUM_CH) ? (ch_rst_o[sel] === 1'b0) : (all_ready_o === 1'b1);
            if (hit) begin
                t = cyc;
                break;
            end
            if (i < budget) tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, te, tf;
        int n0, n1;
        bit seen;
        sys_rst      = 1'b1;
        pll_locked_i = 1'b0;
        div_ratio_i  = '0;
        set_ratio(0, 5);
        set_ratio(1, 0);
        repeat (3) tick();
        chk_eq("rst_ch_rst", ch_rst_o, 2'b11);
        chk_eq("rst_ce", ce_o, 2'b00);
        chk_eq("rst_ready", all_ready_o, 1'b0);

        // Power-up sequence
        sys_rst = 1'b0;
        repeat (5) tick();
        pll_locked_i = 1'b1;
        t0 = cyc;
        wait_evt(0, 40, tf);
        chk_eq("rel0_time", tf, t0 + 11);
        wait_evt(1, 40, tf);
        chk_eq("rel1_time", tf, t0 + 15);
        wait_evt(NUM_CH, 40, tf);
        chk_eq("ready_time", tf, t0 + 16);

        // Divider rates in RUN
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n0 += int'(ce_o[0]);
            n1 += int'(ce_o[1]);
        end
        chk_eq("ce0_count", n0, 4);
        chk_eq("ce1_count", n1, 20);

        // Ratio change 10 -> 3 at count 7
        set_ratio(0, 10);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            seen = ce_o[0];
        end
        chk_eq("rchg_sync", seen, 1'b1);
        repeat (7) tick();
        set_ratio(0, 3);
        tick();
        chk_eq("rchg_imm", ce_o[0], 1'b1);
        tick();
        chk_eq("rchg_gap1", ce_o[0], 1'b0);
        tick();
        chk_eq("rchg_gap2", ce_o[0], 1'b0);
        tick();
        chk_eq("rchg_per", ce_o[0], 1'b1);

        // Lock loss in RUN
        pll_locked_i = 1'b0;
        repeat (2) tick();
        chk_eq("loss_hold_rst", ch_rst_o, 2'b00);
        chk_eq("loss_hold_rdy", all_ready_o, 1'b1);
        tick();
        chk_eq("loss_rst", ch_rst_o, 2'b11);
        chk_eq("loss_rdy", all_ready_o, 1'b0);
`ifdef LOCK_LOSS_CNT_EN
        chk_eq("loss_cnt1", lock_lost_cnt_o, 8'd1);
`endif

        // One-cycle glitch while STABLE count is 5
        repeat (3) tick();
        pll_locked_i = 1'b1;
        t1 = cyc;
        repeat (6) tick();
        pll_locked_i = 1'b0;
        tick();
        pll_locked_i = 1'b1;
        t2 = cyc;
        chk_eq("glitch_t", t2, t1 + 7);
        wait_evt(0, 40, tf);
        chk_eq("glitch_rel0", tf, t2 + 11);

        // sys_rst in RELEASE after ch0 released
        tick();
        sys_rst = 1'b1;
        tick();
        te = cyc;
        chk_eq("srst_rst", ch_rst_o, 2'b11);
        chk_eq("srst_ce", ce_o, 2'b00);
        chk_eq("srst_rdy", all_ready_o, 1'b0);
        sys_rst = 1'b0;
        wait_evt(0, 40, tf);
        chk_eq("srst_rel0", tf, te + 11);
        wait_evt(NUM_CH, 40, tf);
        chk_eq("srst_ready", tf, te + 16);

        // Randomized epochs
        for (int ep = 0; ep < 16; ep++) begin
            set_ratio(0, $urandom_range(0, 12));
            set_ratio(1, $urandom_range(0, 12));
            pll_locked_i = 1'b1;
            n0 = $urandom_range(2, 45);
            for (int i = 0; i < n0; i++) begin
                if ($urandom_range(0, 15) == 0) set_ratio($urandom_range(0, NUM_CH - 1), $urandom_range(0, 12));
                tick();
            end
            if ($urandom_range(0, 5) == 0) begin
                sys_rst = 1'b1;
                repeat ($urandom_range(1, 2)) tick();
                sys_rst = 1'b0;
            end
            pll_locked_i = 1'b0;
            repeat ($urandom_range(1, 6)) tick();
        end

`ifdef LOCK_LOSS_CNT_EN
        // Lock-loss counter saturation
        for (int i = 0; i < 300; i++) begin
            pll_locked_i = 1'b1;
            repeat (4) tick();
            pll_locked_i = 1'b0;
            repeat (4) tick();
        end
        chk_eq("loss_sat", lock_lost_cnt_o, 8'd255);
`endif

        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_rst_seq.md
# clk_rst_seq

Parametrised clock-enable and reset sequencer sitting behind the MMCM wrapper in the clock-generation path. Instead of AND-gating clocks with LOCKED, it synchronises and debounces the PLL lock flag. It then releases per-channel synchronous resets in a staggered order and produces per-channel divided clock-enable strobes, such as the ADS sample enable, on the single system clock. Any loss of lock re-asserts every channel reset.

## Interface
Parameters:
- NUM_CH, 2 — number of downstream channels (1..8)
- DIV_W, 16 — width of each divide-ratio field
- LOCK_STABLE, 1024 — consecutive synchronised-lock cycles required before release (≥2)
- RST_STAGGER, 16 — cycles between successive channel reset releases (≥1)

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst  in  1  synchronous reset, active-high
- pll_locked_i  in  1  MMCM LOCKED, asynchronous to sys_clk
- div_ratio_i  in  NUM_CH*DIV_W  per-channel divide ratio; channel k in bits [k*DIV_W +: DIV_W]
- ce_o  out  NUM_CH  per-channel one-cycle clock-enable strobe
- ch_rst_o  out  NUM_CH  per-channel synchronous reset, active-high
- all_ready_o  out  1  high when every channel is out of reset and lock is good
- lock_lost_cnt_o  out  8  saturating lock-loss event count (only with LOCK_LOSS_CNT_EN)

## Operation
- Lock input: 2-flop synchroniser gives lock_s. Deglitching comes from the stable counter only.
- FSM states: WAIT_LOCK, STABLE, RELEASE, RUN.
  - WAIT_LOCK: stab_cnt=0. When lock_s=1, go to STABLE.
  - STABLE: stab_cnt increments each cycle with lock_s=1. When stab_cnt reaches LOCK_STABLE-1, go to RELEASE with rel_idx=0 and gap_cnt=0.
  - RELEASE: deassert ch_rst_o[rel_idx]. Wait RST_STAGGER cycles, then increment rel_idx. After channel NUM_CH-1 is deasserted, go to RUN.
  - RUN: all_ready_o=1.
- Lock loss: lock_s=0 in STABLE, RELEASE or RUN goes to WAIT_LOCK. On the same clock edge, all ch_rst_o are set to 1, all_ready_o is cleared, and all counters are cleared. Loss takes priority over every other transition in the same cycle.
- Clock enable, per channel k:
  - div_cnt[k] is held at 0 while ch_rst_o[k]=1.
  - Otherwise div_cnt[k] increments. When div_cnt[k] ≥ div_ratio[k]-1, ce_o[k]=1 for that cycle and div_cnt[k] wraps to 0.
  - Ratios 0 and 1: ce_o[k] is constant 1 while out of reset.
  - Ratio changes take effect immediately. The ≥ compare guarantees a wrap within one cycle when the ratio is reduced below the current count.
- Arithmetic: div_cnt is DIV_W bits. stab_cnt is $clog2(LOCK_STABLE) bits. gap_cnt is $clog2(RST_STAGGER+1) bits. No counter is allowed to overflow.

## Timing
Reset values, sys_rst=1: state=WAIT_LOCK, ch_rst_o=all 1, ce_o=0, all_ready_o=0, lock_lost_cnt_o=0, synchroniser flops=0. sys_rst takes priority over lock activity.

Latencies and cycle rules:
- pll_locked_i rising to lock_s: 2 cycles.
- lock_s=1 to ch_rst_o[0] low: LOCK_STABLE+1 cycles.
- ch_rst_o[k] low to ch_rst_o[k+1] low: exactly RST_STAGGER cycles.
- all_ready_o rises 1 cycle after ch_rst_o[NUM_CH-1] falls.
- First ce_o[k] pulse: div_ratio[k] cycles after ch_rst_o[k] falls (1 cycle for ratio 0/1).
- pll_locked_i falling to all ch_rst_o high: 3 cycles (2 sync + 1 register).
- Lock drop during STABLE: no channel has been released yet. The next attempt restarts the full LOCK_STABLE count.
- NUM_CH=1: RELEASE lasts one cycle.
- All outputs are registered.

## Configuration
- LOCK_LOSS_CNT_EN defined:
  - lock_lost_cnt_o is present.
  - It increments on each STABLE/RELEASE/RUN → WAIT_LOCK transition and saturates at 255.
  - It is cleared only by sys_rst.
- LOCK_LOSS_CNT_EN undefined: the port and the counter are absent. No other behaviour changes.

## Structure
- Shared package clk_rst_pkg holds:
  - the FSM state enum (WAIT_LOCK, STABLE, RELEASE, RUN);
  - the lock-loss counter width constant (8);
  - the default LOCK_STABLE and RST_STAGGER constants.
- One sub-module, ce_div: a single-channel divider taking ratio, rst and clk, producing ce. It is instantiated NUM_CH times in a generate loop. The FSM and the synchroniser stay in the top level.

## Test plan
- Power-up, NUM_CH=2, LOCK_STABLE=8, RST_STAGGER=4. Raise pll_locked_i at cycle 10 → ch_rst_o[0] falls at cycle 21, ch_rst_o[1] at 25, all_ready_o rises at 26.
- Divider, div_ratio ch0=5, ch1=0 → ce_o[0] pulses every 5th cycle starting 5 cycles after release; ce_o[1] held at 1.
- Lock glitch: drop pll_locked_i for 1 cycle during STABLE at count 5 → no release occurs; full 8-cycle count restarts after lock returns.
- Lock loss in RUN → ch_rst_o=2'b11 and all_ready_o=0 three cycles later. With LOCK_LOSS_CNT_EN, lock_lost_cnt_o becomes 1. Repeat 300 times → saturates at 255.
- Ratio change in RUN from 10 to 3 while div_cnt=7 → ce pulse on the next cycle, then every 3 cycles.
- Assert sys_rst mid-RELEASE, after ch0 is released → all outputs return to reset values on the next edge. The sequence restarts from WAIT_LOCK.
